// File: rtl/ps2_pkg.sv
// Shared constants and payload types for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;

    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_CNT_W      = 4;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_evt_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
    } key_hold_t;

endpackage

// File: rtl/ps2_key_rx_if.sv
// Key event and hold-state bus from the PS/2 receiver to the game logic.
interface ps2_key_rx_if;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic [7:0] held_key;
    logic       held_ext;
    logic       frame_err;

    modport master (
        output key_valid, key_code, key_ext, key_break,
        output held_key, held_ext, frame_err
    );

    modport slave (
        input key_valid, key_code, key_ext, key_break,
        input held_key, held_ext, frame_err
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 deframer: synchronises kclk/kdata, collects 11-bit frames,
// checks start/parity/stop and abandons stalled partial frames.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kclk,
    input  logic       kdata,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err,
    output logic       byte_timeout
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned SH_W = PS2_FRAME_BITS - 1;

    logic [2:0]           kclk_sync;
    logic [1:0]           kdata_sync;
    logic [PS2_CNT_W-1:0] bit_cnt;
    logic [SH_W-1:0]      shift;
    logic [TO_W-1:0]      to_cnt;

    logic fall;
    logic kbit;
    logic last_bit;
    logic frame_ok;

    assign fall     = kclk_sync[2] & ~kclk_sync[1];
    assign kbit     = kdata_sync[1];
    assign last_bit = (bit_cnt == PS2_CNT_W'(PS2_FRAME_BITS - 1));
    // shift holds start at [0], d0..d7 at [8:1], parity at [9]; kbit is the stop bit
    assign frame_ok = ~shift[0] & kbit & (^shift[9:1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            kclk_sync    <= '1;
            kdata_sync   <= '1;
            bit_cnt      <= '0;
            shift        <= '0;
            to_cnt       <= '0;
            byte_valid   <= 1'b0;
            byte_err     <= 1'b0;
            byte_data    <= '0;
            byte_timeout <= 1'b0;
        end else begin
            kclk_sync    <= {kclk_sync[1:0], kclk};
            kdata_sync   <= {kdata_sync[0], kdata};
            byte_valid   <= 1'b0;
            byte_err     <= 1'b0;
            byte_timeout <= 1'b0;

            if (fall) begin
                to_cnt <= '0;
                if (last_bit) begin
                    bit_cnt    <= '0;
                    byte_valid <= frame_ok;
                    byte_err   <= ~frame_ok;
                    byte_data  <= shift[8:1];
                end else begin
                    bit_cnt <= bit_cnt + PS2_CNT_W'(1);
                    shift   <= {kbit, shift[SH_W-1:1]};
                end
            end else if (bit_cnt != '0) begin
                // saturating idle counter; reaching the limit abandons the frame once
                if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    to_cnt       <= TO_W'(TIMEOUT_CYC);
                    bit_cnt      <= '0;
                    byte_timeout <= 1'b1;
                end else if (to_cnt != TO_W'(TIMEOUT_CYC)) begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: decodes E0/F0 prefixes into make/break events
// and tracks the most recently pressed key for the game logic.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          kclk,
    input  logic          kdata,
    ps2_key_rx_if.master  kbus
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_err;
    logic       byte_timeout;

    ps2_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame (
        .clk          (clk),
        .rst          (rst),
        .kclk         (kclk),
        .kdata        (kdata),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_err     (byte_err),
        .byte_timeout (byte_timeout)
    );

    logic      ext_pend,  ext_pend_n;
    logic      brk_pend,  brk_pend_n;
    logic      key_valid, key_valid_n;
    logic      frame_err, frame_err_n;
    key_evt_t  evt_q,     evt_n;
    key_hold_t hold_q,    hold_n;

    always_comb begin
        ext_pend_n  = ext_pend;
        brk_pend_n  = brk_pend;
        key_valid_n = 1'b0;
        frame_err_n = 1'b0;
        evt_n       = evt_q;
        hold_n      = hold_q;

        if (byte_err) begin
            frame_err_n = 1'b1;
            ext_pend_n  = 1'b0;
            brk_pend_n  = 1'b0;
        end else if (byte_timeout) begin
            ext_pend_n = 1'b0;
            brk_pend_n = 1'b0;
        end else if (byte_valid) begin
            case (byte_data)
                PS2_EXT: ext_pend_n = 1'b1;
                PS2_BRK: brk_pend_n = 1'b1;
                default: begin
                    key_valid_n = 1'b1;
                    evt_n       = '{code: byte_data, ext: ext_pend, brk: brk_pend};
                    ext_pend_n  = 1'b0;
                    brk_pend_n  = 1'b0;
                    // last press wins; only releasing the held key clears it
                    if (!brk_pend) begin
                        hold_n = '{code: byte_data, ext: ext_pend};
                    end else if (hold_q.code == byte_data && hold_q.ext == ext_pend) begin
                        hold_n = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            evt_q     <= '0;
            hold_q    <= '0;
        end else begin
            ext_pend  <= ext_pend_n;
            brk_pend  <= brk_pend_n;
            key_valid <= key_valid_n;
            frame_err <= frame_err_n;
            evt_q     <= evt_n;
            hold_q    <= hold_n;
        end
    end

    assign kbus.key_valid = key_valid;
    assign kbus.key_code  = evt_q.code;
    assign kbus.key_ext   = evt_q.ext;
    assign kbus.key_break = evt_q.brk;
    assign kbus.held_key  = hold_q.code;
    assign kbus.held_ext  = hold_q.ext;
    assign kbus.frame_err = frame_err;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: PS/2 frames in, expected events queued
// by a behavioural keyboard model, checked by an independent monitor.
module tb_ps2_key_rx;
    import ps2_pkg::*;

    localparam int unsigned TO_CYC = 300;

    logic clk = 1'b0;
    logic rst;
    logic kclk;
    logic kdata;

    ps2_key_rx_if kif();

    ps2_key_rx #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk   (clk),
        .rst   (rst),
        .kclk  (kclk),
        .kdata (kdata),
        .kbus  (kif)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         ext;
        bit         brk;
        logic [7:0] held;
        bit         held_ext;
        int         exp_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // behavioural keyboard state
    bit         m_ext, m_brk, m_held_ext;
    logic [7:0] m_held;
    int         hp = 6;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_held = 8'h00; m_held_ext = 0;
    endtask

    // fold one received byte into the model, queueing any event it yields
    task automatic model_byte(input logic [7:0] d, input bit bad, input int ecyc);
        exp_t e;
        e.exp_cyc = ecyc;
        if (bad) begin
            m_ext = 0; m_brk = 0;
            e.is_err = 1; e.code = 0; e.ext = 0; e.brk = 0;
            e.held = m_held; e.held_ext = m_held_ext;
            sb.push_back(e);
        end else if (d == 8'hE0) begin
            m_ext = 1;
        end else if (d == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (!m_brk) begin
                m_held = d; m_held_ext = m_ext;
            end else if (m_held == d && m_held_ext == m_ext) begin
                m_held = 8'h00; m_held_ext = 0;
            end
            e.is_err = 0; e.code = d; e.ext = m_ext; e.brk = m_brk;
            e.held = m_held; e.held_ext = m_held_ext;
            m_ext = 0; m_brk = 0;
            sb.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // drive nbits of a frame; a full 11-bit frame is reported to the model
    task automatic send_bits(input logic [7:0] d, input bit bad, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~(^d)) ^ bad, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            kdata = bits[i];
            wait_cyc(hp);
            kclk = 1'b0;
            if (i == 10) model_byte(d, bad, cyc + 4);
            wait_cyc(hp);
            kclk = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit bad = 0);
        send_bits(d, bad, 11);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(sb.size()), 0);
    endtask

    // monitor: every presented event is matched against the scoreboard head
    always @(negedge clk) begin
        if (!rst && (kif.key_valid || kif.frame_err)) begin
            check("exclusive", {31'b0, kif.key_valid & kif.frame_err}, 0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: key_valid=%0b frame_err=%0b code=%0h expected none",
                         kif.key_valid, kif.frame_err, kif.key_code);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("frame_err", {31'b0, kif.frame_err}, {31'b0, e.is_err});
                check("latency", cyc, e.exp_cyc);
                if (!e.is_err) begin
                    check("key_code",  {24'b0, kif.key_code}, {24'b0, e.code});
                    check("key_ext",   {31'b0, kif.key_ext},   {31'b0, e.ext});
                    check("key_break", {31'b0, kif.key_break}, {31'b0, e.brk});
                end
                check("held_key", {24'b0, kif.held_key}, {24'b0, e.held});
                check("held_ext", {31'b0, kif.held_ext}, {31'b0, e.held_ext});
            end
        end
    end

    logic [7:0] keys [6];

    initial begin
        keys[0] = KEY_LEFT;  keys[1] = KEY_RIGHT; keys[2] = KEY_UP;
        keys[3] = KEY_DOWN;  keys[4] = KEY_ENTER; keys[5] = KEY_SPACE;

        rst = 1'b1; kclk = 1'b1; kdata = 1'b1;
        model_reset();
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(2);
        check("reset_key_valid", {31'b0, kif.key_valid}, 0);
        check("reset_frame_err", {31'b0, kif.frame_err}, 0);
        check("reset_key_code",  {24'b0, kif.key_code}, 0);
        check("reset_key_flags", {30'b0, kif.key_ext, kif.key_break}, 0);
        check("reset_held",      {23'b0, kif.held_ext, kif.held_key}, 0);

        // left arrow press then release
        send(8'hE0); send(KEY_LEFT);
        wait_cyc(10);
        send(8'hE0); send(8'hF0); send(KEY_LEFT);
        wait_drain();

        // bad parity, then a good space
        send(KEY_UP);
        send(KEY_ENTER, 1);
        send(KEY_SPACE);
        wait_drain();

        // stalled partial frame after an E0 prefix, then a full right-arrow frame
        send(8'hE0);
        send_bits(8'h55, 0, 5);
        wait_cyc(TO_CYC + 10);
        m_ext = 0; m_brk = 0;
        send(KEY_RIGHT);
        wait_drain();

        // overlapping presses
        send(KEY_LEFT); send(KEY_RIGHT);
        send(8'hF0); send(KEY_LEFT);
        send(8'hF0); send(KEY_RIGHT);
        wait_drain();

        // reset after a break prefix
        send(KEY_DOWN);
        send(8'hF0);
        wait_cyc(10);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        model_reset();
        wait_cyc(1);
        check("rst_mid_held", {24'b0, kif.held_key}, 0);
        send(KEY_ENTER);
        wait_drain();

        // back-to-back frames with no idle gap
        hp = 4;
        send(8'hE0); send(KEY_UP);
        wait_drain();

        // randomized key traffic
        for (int n = 0; n < 30; n++) begin
            logic [7:0] k;
            int op;
            k  = keys[$urandom_range(5, 0)];
            op = int'($urandom_range(5, 0));
            hp = int'($urandom_range(10, 3));
            case (op)
                0: send(k);
                1: begin send(8'hE0); send(k); end
                2: begin send(8'hF0); send(k); end
                3: begin send(8'hE0); send(8'hF0); send(k); end
                4: begin send(8'hE0); send(k, 1); end
                default: begin send(m_held); end
            endcase
            wait_cyc(int'($urandom_range(20, 0)));
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_key_rx.md
# ps2_key_rx

PS/2 keyboard receiver feeding the game top level: synchronises `kclk`/`kdata`, deframes 11-bit device-to-host frames, checks start/parity/stop, and decodes the E0 (extended) and F0 (break) prefixes. It outputs a one-cycle event per key make or break, plus a level `held_key` holding the most recently pressed key until that key is released. The fish movement logic consumes `held_key` in place of raw shift-register bits, so a stale or corrupted frame never steers a fish.

## Interface
- `TIMEOUT_CYC`, 100000: idle `clk` cycles (2 ms at 50 MHz) after which a partial frame is discarded.
- `clk` in 1: system clock, 50 MHz; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `kclk` in 1: raw PS/2 clock, asynchronous.
- `kdata` in 1: raw PS/2 data, asynchronous.
- `key_valid` out 1: one-cycle pulse; the `key_code`/`key_ext`/`key_break` event outputs are valid.
- `key_code` out 8: scan code of the event, without prefix bytes.
- `key_ext` out 1: the event was preceded by E0.
- `key_break` out 1: the event was preceded by F0 (key release).
- `held_key` out 8: code of the currently held key; 8'h00 when no key is held.
- `held_ext` out 1: extended flag of `held_key`.
- `frame_err` out 1: one-cycle pulse on a start, parity or stop violation.

## Operation
- **Synchroniser.** `kclk` and `kdata` each pass through two flops. A falling edge is detected on the synchronised `kclk` against a third delayed copy. `kdata` is sampled from its synchronised copy on each detected fall.
- **Deframer.**
  - Bit counter runs 0..10; frame bit order is start(0), d0..d7 (LSB first), odd parity, stop(1).
  - On the 11th fall the frame is good only if start==0, stop==1 and XOR(d0..d7, parity)==1.
  - Counter returns to 0 after every 11th fall, whether the frame is good or bad.
- **Decoder state (two flags).**
  - `ext_pend` is set by a good byte E0.
  - `brk_pend` is set by a good byte F0.
  - Prefix bytes produce no `key_valid`.
  - Any other good byte pulses `key_valid` with `key_ext`=`ext_pend`, `key_break`=`brk_pend`, then clears both flags.
- **Hold register.**
  - Make event: `held_key`<=code, `held_ext`<=ext.
  - Break event whose code and ext both match the hold register: `held_key`<=8'h00, `held_ext`<=0.
  - Break event for any other key: hold register unchanged.
  - Make of a new key while another is held: the new key overwrites (last-pressed wins).
- **Bad frame.** Pulse `frame_err`, no `key_valid`, clear `ext_pend` and `brk_pend`; hold register unchanged.
- **Timeout.** If the bit counter is non-zero and no fall occurs for `TIMEOUT_CYC` consecutive cycles:
  - counter returns to 0;
  - both pend flags clear;
  - no pulses are issued.
- **Reset values.** All outputs 0. Counter, pend flags and timeout counter 0. Synchroniser flops 1 (idle bus).

## Timing
- Latency: `key_valid` (or `frame_err`) is high in the cycle after the 4th rising `clk` edge following the first edge that samples raw `kclk` low for the 11th time.
  - Edges 1–2: synchroniser.
  - Edge 3: shift in bit 11.
  - Edge 4: registered outputs.
- `held_key` and `held_ext` update on the same edge that asserts `key_valid`.
- `key_code`, `key_ext` and `key_break` hold their values until the next event; only `key_valid` returns to 0 after one cycle.
- `key_valid` and `frame_err` are never high in the same cycle.
- Timeout counter:
  - resets on every detected fall;
  - saturates, so it does not wrap;
  - fires exactly once per stalled frame.
- `rst` asserted mid-frame: the partial frame is dropped; the next fall is treated as a start bit.
- Back-to-back frames with no idle gap between the stop bit and the next start bit are handled; no dead cycles are required.

## Structure
- Package `ps2_pkg`:
  - prefixes `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0;
  - game keys `KEY_LEFT`=8'h6B, `KEY_RIGHT`=8'h74, `KEY_UP`=8'h75, `KEY_DOWN`=8'h72, `KEY_ENTER`=8'h5A, `KEY_SPACE`=8'h29;
  - `PS2_FRAME_BITS`=11.
- Sub-module `ps2_frame_rx`: synchroniser, fall detect, bit counter, shift register, frame check and timeout. It outputs `byte_valid`, `byte_data[7:0]` and `byte_err`.
- `ps2_key_rx` adds the prefix flags and the hold register.

## Test plan
- **Left arrow, press then release.** Send E0 6B, then E0 F0 6B.
  - First event: `key_valid` with `key_code`=6B, `key_ext`=1, `key_break`=0; `held_key`=6B.
  - Second event: `key_break`=1; `held_key`=00.
- **Bad parity.** Send 5A with even parity.
  - `frame_err` pulses once; no `key_valid`; `held_key` unchanged.
  - A following good 29 yields `key_code`=29, `key_ext`=0.
- **Stalled frame.** Deliver 5 falls, then stall for `TIMEOUT_CYC`+10 cycles, then send a full 74 frame.
  - Exactly one `key_valid`, with `key_code`=74; no `frame_err`.
- **Overlapping presses.** Press 6B, press 74, release 6B.
  - `held_key` goes 6B → 74 and stays 74.
  - Releasing 74 then gives 00.
- **Reset mid-prefix.** Assert `rst` after the F0 byte, then send 5A.
  - Event `key_break`=0; `held_key`=5A.
- **Back-to-back frames.** Send E0 75 with no idle gap.
  - One event; latency measured as specified (cycle after the 4th edge).
